// File: rtl/dmem_io_bridge.sv
// dmem_io_bridge: memory-mapped I/O bridge on the core data-memory port.
// The top 16 bytes of the data address space (IO_BASE) are decoded into an
// output FIFO (TXDATA), a status register (STATUS) and an optional cycle
// counter (CYCLES). All other accesses pass straight through to the RAM.
// Optional feature: define IO_CYCLE_CNT_EN to build the 32-bit cycle counter;
// without it CYCLES reads as 0 and stores to it are ignored.
module dmem_io_bridge #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 10,
    parameter int              DEPTH   = 8,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h3F0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ram_MemWrite,
    output logic              ram_MemRead,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLES = 2'd2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_io_sel;
    logic [1:0]        w_reg;
    logic              w_full;
    logic              w_empty;
    logic              w_tx_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_ovf_clr;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_cycles;
    logic              w_unused;

    // Byte-lane bits never matter for word-sized I/O registers.
    assign w_unused  = ^address[1:0];

    assign w_io_sel  = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign w_reg     = address[3:2];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);

    // Full is judged on the pre-edge count, so a same-cycle pop cannot
    // rescue a store that arrives while full.
    assign w_tx_wr   = MemWrite & w_io_sel & (w_reg == REG_TXDATA);
    assign w_push    = w_tx_wr & ~w_full;
    assign w_drop    = w_tx_wr & w_full;
    assign w_pop     = out_valid & out_ready;
    assign w_ovf_clr = MemWrite & w_io_sel & (w_reg == REG_STATUS) & write_data[10];

    assign ram_MemWrite = MemWrite & ~w_io_sel;
    assign ram_MemRead  = MemRead & ~w_io_sel;

    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

    // STATUS layout: overflow at bit 10, empty 9, full 8, count in [7:0].
    always_comb begin
        w_status     = '0;
        w_status[10] = r_overflow;
        w_status[9]  = w_empty;
        w_status[8]  = w_full;
        w_status[7:0] = 8'(r_count);
    end

    // FIFO storage: written on accepted pushes only, deliberately not reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats a clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef IO_CYCLE_CNT_EN
    logic [31:0] r_cycles;
    logic        w_cyc_clr;

    assign w_cyc_clr = MemWrite & w_io_sel & (w_reg == REG_CYCLES);
    assign w_cycles  = DATA_W'(r_cycles);

    // Free-running cycle counter; a store to CYCLES restarts it from zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cycles <= '0;
        end else if (w_cyc_clr) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end
`else
    assign w_cycles = '0;
`endif

    // Load data mux: RAM outside the window, register map inside it.
    always_comb begin
        read_data = '0;
        if (!w_io_sel) begin
            read_data = ram_read_data;
        end else begin
            case (w_reg)
                REG_STATUS: read_data = w_status;
                REG_CYCLES: read_data = w_cycles;
                default:    read_data = '0;
            endcase
        end
    end

endmodule
